// File: rtl/window_minmax_tracker_pkg.sv
// window_minmax_tracker_pkg
//   Shared definitions for the window min/max tracker and its comparator.
//   DATA_W     : sample width (unsigned)
//   state_t    : tracker FSM states, 2-bit encoding
//   idx_width  : width of index/counter for a given window length
package window_minmax_tracker_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // A window of one sample still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/window_minmax_tracker_cmp.sv
// window_minmax_tracker_cmp
//   Unsigned magnitude comparator; exactly one of gt/lt/eq is high.
//   a   in  DATA_W  left operand
//   b   in  DATA_W  right operand
//   gt  out 1       a > b
//   lt  out 1       a < b
//   eq  out 1       a == b
module window_minmax_tracker_cmp
  import window_minmax_tracker_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              gt,
  output logic              lt,
  output logic              eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/window_minmax_tracker.sv
// window_minmax_tracker
//   Tracks max/min (and their 0-based positions) over each window of
//   WINDOW_LEN accepted samples, then offers the result downstream.
//   clk           in   1      system clock, rising edge
//   rst           in   1      asynchronous active-high reset
//   clear         in   1      synchronous abort of the current window
//   sample_valid  in   1      sample presented
//   sample_ready  out  1      sample accepted this cycle (state decode)
//   sample        in   16     unsigned sample
//   result_valid  out  1      window result available (state decode)
//   result_ready  in   1      consumer takes the result
//   max_val       out  16     largest sample in window
//   min_val       out  16     smallest sample in window
//   max_idx       out  IDX_W  position of max_val
//   min_idx       out  IDX_W  position of min_val
//
//   state | meaning
//   IDLE  | waiting for the first sample of a window
//   ACCUM | collecting samples 1..WINDOW_LEN-1
//   HOLD  | result presented, waiting for result_ready
module window_minmax_tracker
  import window_minmax_tracker_pkg::*;
#(
  parameter  int WINDOW_LEN = 8,
  localparam int IDX_W      = idx_width(WINDOW_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] min_val,
  output logic [IDX_W-1:0]  max_idx,
  output logic [IDX_W-1:0]  min_idx
);

  localparam logic [IDX_W-1:0] LAST_CNT  = IDX_W'(WINDOW_LEN - 1);
  localparam logic [IDX_W-1:0] FIRST_CNT = (WINDOW_LEN == 1) ? '0 : IDX_W'(1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [DATA_W-1:0] max_q, min_q;
  logic [IDX_W-1:0]  max_idx_q, min_idx_q;
  logic              accept;

  logic max_gt, max_lt, max_eq;
  logic min_gt, min_lt, min_eq;
  logic unused_cmp;

  window_minmax_tracker_cmp u_cmp_max (
    .a  (sample),
    .b  (max_q),
    .gt (max_gt),
    .lt (max_lt),
    .eq (max_eq)
  );

  window_minmax_tracker_cmp u_cmp_min (
    .a  (sample),
    .b  (min_q),
    .gt (min_gt),
    .lt (min_lt),
    .eq (min_eq)
  );

  // Ties keep the stored value, so only the strict flags drive updates.
  assign unused_cmp = ^{max_lt, max_eq, min_gt, min_eq};

  assign sample_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign result_valid = (state_q == HOLD);
  assign accept       = sample_valid && sample_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (WINDOW_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (cnt_q == LAST_CNT)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (clear) begin
      cnt_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            max_q     <= sample;
            min_q     <= sample;
            max_idx_q <= '0;
            min_idx_q <= '0;
            cnt_q     <= FIRST_CNT;
          end
        end
        ACCUM: begin
          if (sample_valid) begin
            if (max_gt) begin
              max_q     <= sample;
              max_idx_q <= cnt_q;
            end
            if (min_lt) begin
              min_q     <= sample;
              min_idx_q <= cnt_q;
            end
            // Park on the last position so cnt never passes WINDOW_LEN-1.
            if (cnt_q != LAST_CNT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (result_ready) begin
            cnt_q <= '0;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign max_val = max_q;
  assign min_val = min_q;
  assign max_idx = max_idx_q;
  assign min_idx = min_idx_q;

endmodule

// File: tb/tb_window_minmax_tracker.sv
module tb_window_minmax_tracker;

  localparam int NA = 8;
  localparam int NB = 1;

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] mn;
    logic [15:0] mxi;
    logic [15:0] mni;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear, sample_valid, result_ready;
  logic [15:0] sample;

  logic        a_sample_ready, a_result_valid;
  logic [15:0] a_max_val, a_min_val;
  logic [2:0]  a_max_idx, a_min_idx;
  logic        b_sample_ready, b_result_valid;
  logic [15:0] b_max_val, b_min_val;
  logic [0:0]  b_max_idx, b_min_idx;

  window_minmax_tracker #(.WINDOW_LEN(NA)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .sample_valid(sample_valid), .sample_ready(a_sample_ready), .sample(sample),
    .result_valid(a_result_valid), .result_ready(result_ready),
    .max_val(a_max_val), .min_val(a_min_val), .max_idx(a_max_idx), .min_idx(a_min_idx)
  );

  window_minmax_tracker #(.WINDOW_LEN(NB)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .sample_valid(sample_valid), .sample_ready(b_sample_ready), .sample(sample),
    .result_valid(b_result_valid), .result_ready(result_ready),
    .max_val(b_max_val), .min_val(b_min_val), .max_idx(b_max_idx), .min_idx(b_min_idx)
  );

  int checks = 0;
  int failures = 0;

  // Reference: first occurrence of the strict max and strict min.
  function automatic res_t ref_res(input logic [15:0] w[$]);
    res_t r;
    r.mx = w[0]; r.mn = w[0]; r.mxi = 16'd0; r.mni = 16'd0;
    for (int i = 1; i < w.size(); i++) begin
      if (w[i] > r.mx) begin r.mx = w[i]; r.mxi = 16'(i); end
      if (w[i] < r.mn) begin r.mn = w[i]; r.mni = 16'(i); end
    end
    return r;
  endfunction

  // Model state: h = result pending, k = outputs have a defined value e.
  logic [15:0] wa[$];
  logic [15:0] wb[$];
  logic ha, ka, hb, kb;
  res_t ea, eb;
  res_t lit_a[$];
  res_t lit_b[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ha <= 1'b0; ka <= 1'b1; ea <= '0; wa.delete();
    end else if (clear) begin
      ha <= 1'b0; ka <= 1'b1; ea <= '0; wa.delete();
    end else if (ha) begin
      if (result_ready) ha <= 1'b0;
    end else if (sample_valid) begin
      wa.push_back(sample);
      if (wa.size() == NA) begin
        ea <= ref_res(wa); ha <= 1'b1; ka <= 1'b1; wa.delete();
      end else begin
        ka <= 1'b0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hb <= 1'b0; kb <= 1'b1; eb <= '0; wb.delete();
    end else if (clear) begin
      hb <= 1'b0; kb <= 1'b1; eb <= '0; wb.delete();
    end else if (hb) begin
      if (result_ready) hb <= 1'b0;
    end else if (sample_valid) begin
      wb.push_back(sample);
      if (wb.size() == NB) begin
        eb <= ref_res(wb); hb <= 1'b1; kb <= 1'b1; wb.delete();
      end else begin
        kb <= 1'b0;
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    res_t l;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      cmp("a_sample_ready", 32'(a_sample_ready), 32'(!ha));
      cmp("a_result_valid", 32'(a_result_valid), 32'(ha));
      if (ka) begin
        cmp("a_max_val", 32'(a_max_val), 32'(ea.mx));
        cmp("a_min_val", 32'(a_min_val), 32'(ea.mn));
        cmp("a_max_idx", 32'(a_max_idx), 32'(ea.mxi));
        cmp("a_min_idx", 32'(a_min_idx), 32'(ea.mni));
      end
      cmp("b_sample_ready", 32'(b_sample_ready), 32'(!hb));
      cmp("b_result_valid", 32'(b_result_valid), 32'(hb));
      if (kb) begin
        cmp("b_max_val", 32'(b_max_val), 32'(eb.mx));
        cmp("b_min_val", 32'(b_min_val), 32'(eb.mn));
        cmp("b_max_idx", 32'(b_max_idx), 32'(eb.mxi));
        cmp("b_min_idx", 32'(b_min_idx), 32'(eb.mni));
      end
      if (!rst && !clear && ha && result_ready && lit_a.size() > 0) begin
        l = lit_a.pop_front();
        cmp("lit_a_max_val", 32'(a_max_val), 32'(l.mx));
        cmp("lit_a_min_val", 32'(a_min_val), 32'(l.mn));
        cmp("lit_a_max_idx", 32'(a_max_idx), 32'(l.mxi));
        cmp("lit_a_min_idx", 32'(a_min_idx), 32'(l.mni));
      end
      if (!rst && !clear && hb && result_ready && lit_b.size() > 0) begin
        l = lit_b.pop_front();
        cmp("lit_b_max_val", 32'(b_max_val), 32'(l.mx));
        cmp("lit_b_min_val", 32'(b_min_val), 32'(l.mn));
        cmp("lit_b_max_idx", 32'(b_max_idx), 32'(l.mxi));
        cmp("lit_b_min_idx", 32'(b_min_idx), 32'(l.mni));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept();
    logic r;
    int n = 0;
    forever begin
      @(negedge clk);
      r = a_sample_ready;
      @(posedge clk);
      #2;
      if (r) break;
      n++;
      if (n > 200) begin
        $display("FAIL wait_accept timeout actual=busy required=accept");
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic send_window(input logic [15:0] v[$], input bit gaps);
    foreach (v[i]) begin
      sample = v[i];
      sample_valid = 1'b1;
      wait_accept();
      if (gaps) begin
        sample_valid = 1'b0;
        cyc();
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #3 rst = 1'b1;
    #10 rst = 1'b0;
    cyc();
  endtask

  logic [15:0] seq[$];
  logic [15:0] abort_seq[$];

  initial begin
    rst = 1'b0; clear = 1'b0; sample_valid = 1'b0; result_ready = 1'b1; sample = '0;
    #1 rst = 1'b1;
    #11 rst = 1'b0;
    cyc();

    lit_a.push_back('{16'd9, 16'd1, 16'd2, 16'd4});
    seq = '{16'd5, 16'd3, 16'd9, 16'd9, 16'd1, 16'd7, 16'd1, 16'd2};
    send_window(seq, 1'b0);

    lit_a.push_back('{16'h1234, 16'h1234, 16'd0, 16'd0});
    seq = '{8{16'h1234}};
    send_window(seq, 1'b0);

    lit_a.push_back('{16'hFFFF, 16'h0000, 16'd1, 16'd0});
    seq = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE};
    send_window(seq, 1'b0);
    cyc();

    result_ready = 1'b0;
    lit_a.push_back('{16'd300, 16'd25, 16'd6, 16'd4});
    seq = '{16'd100, 16'd50, 16'd200, 16'd50, 16'd25, 16'd200, 16'd300, 16'd25};
    send_window(seq, 1'b1);
    sample_valid = 1'b1; sample = 16'hDEAD;
    repeat (5) cyc();
    result_ready = 1'b1;
    cyc();
    sample_valid = 1'b0;
    cyc();

    abort_seq = '{16'hFFFF, 16'd1, 16'hFFFF, 16'd2};
    seq = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    send_window(abort_seq, 1'b0);
    clear = 1'b1; sample_valid = 1'b1; sample = 16'd0;
    cyc();
    clear = 1'b0; sample_valid = 1'b0;
    lit_a.push_back('{16'd80, 16'd10, 16'd7, 16'd0});
    send_window(seq, 1'b0);
    cyc(); cyc();

    send_window(abort_seq, 1'b0);
    pulse_rst();
    lit_a.push_back('{16'd80, 16'd10, 16'd7, 16'd0});
    send_window(seq, 1'b0);
    cyc(); cyc();

    pulse_rst();
    lit_b.push_back('{16'hABCD, 16'hABCD, 16'd0, 16'd0});
    sample = 16'hABCD; sample_valid = 1'b1;
    cyc();
    sample_valid = 1'b0;
    cyc(); cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      result_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 99) == 0);
      cyc();
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    clear = 1'b0; sample_valid = 1'b0; result_ready = 1'b1;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
